ins_loader: RTL and testbench
=============================

Name: ins_loader

Overview:
- Upstream feeder for the processor top: receives a program as a byte stream from a host link (UART/debug bridge) and writes little-endian 32-bit instructions into instruction memory.
- Once the last word is written, pulses startProcess to the top.
- Holds the write path idle while the program runs, until endProcess returns.

Parameters:
- INSTRUCTION_WIDTH, 32, instruction word width (fixed 32; 4 bytes/word).
- IM_MEM_DEPTH, 512, instruction memory depth in words; maximum loadable program length.
- ADDRESS_WIDTH, 32, width of the instruction memory write byte address.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- load_start  input  1  begin a load; sampled in IDLE and ERR only.
- byte_valid  input  1  byte_data valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_wr_en  output  1  instruction memory write strobe.
- im_wr_addr  output  ADDRESS_WIDTH  word-aligned byte address (4*k).
- im_wr_data  output  INSTRUCTION_WIDTH  assembled instruction.
- startProcess  output  1  one-cycle start pulse to processor top.
- endProcess  input  1  processor finished.
- loader_busy  output  1  high in HDR, DATA, START, RUN.
- load_error  output  1  high in ERR.

Behaviour:
- All outputs registered. On rst (any time, including mid-word):
  - state=IDLE; every output 0; byte/word counters and partial word cleared.
  - Memory contents already written are untouched.
- A byte is accepted when byte_valid && byte_ready. byte_ready=1 only in HDR and DATA.
- States:
  - IDLE: load_start -> HDR.
  - HDR: accept 2 bytes, little-endian 16-bit word count N.
    - After the 2nd byte: N==0 or N>IM_MEM_DEPTH -> ERR.
    - Otherwise -> DATA with word index k=0.
  - DATA: accept bytes, LSB first, into a 32-bit assembly register.
    - On the cycle after the 4th byte of word k is accepted: im_wr_en=1 for exactly one cycle, im_wr_addr=4*k, im_wr_data=assembled word.
    - Byte acceptance continues back-to-back, so a word can be written every 4 cycles with no bubble.
    - After the 4th byte of word N-1 is accepted: byte_ready drops the next cycle (same cycle as the final write) and the state moves to START.
  - START: startProcess=1 for one cycle -> RUN.
  - RUN: wait for endProcess=1 -> IDLE. endProcess in any other state is ignored.
  - ERR: load_error=1, byte_ready=0.
    - load_start -> HDR, clearing load_error the next cycle.
    - Otherwise the state holds.
- load_start in HDR/DATA/START/RUN is ignored.
- byte_valid gaps stall assembly indefinitely; there is no timeout.
- im_wr_addr wraps never: N is bounded, so the maximum address is 4*(IM_MEM_DEPTH-1).
- Between writes, im_wr_addr and im_wr_data hold their last values; im_wr_en=0.
- Latency from the final accepted byte to startProcess is 2 cycles: write cycle, then START.

Test Plan:
- Normal load: bytes 02 00, 13 05 10 00, 93 05 20 00 continuous -> writes (addr 0, 0x00100513) and (addr 4, 0x00200593); startProcess pulses 2 cycles after the last byte; loader_busy=1 until endProcess.
- Backpressure: same stream with byte_valid low for 3 cycles between every byte -> identical writes; no extra im_wr_en pulses; byte_ready stays 1 during gaps.
- Header errors:
  - N=0 (00 00) -> load_error=1 the cycle after the 2nd byte; no writes; no startProcess.
  - N=513 (01 02) -> same.
  - A following load_start with a valid header -> recovers normally.
- Reset mid-word: rst asserted after 2 of 4 bytes of word 1 -> all outputs 0 immediately; a new load from IDLE writes word 0 at addr 0 with no leftover bytes.
- Ignored load_start: pulse load_start during DATA and during RUN -> no state change, no counter reset; endProcess=1 in RUN -> loader_busy=0 next cycle.
- Max size: N=512 -> 512 writes, last at addr 0x7FC, then one startProcess pulse.

Source files
------------

// File: rtl/ins_loader_if.sv
// Host-side byte stream, instruction-memory write port and processor start/end
// handshake for the program loader.
interface ins_loader_if #(
    parameter int unsigned ADDRESS_WIDTH     = 32,
    parameter int unsigned INSTRUCTION_WIDTH = 32
);
    logic                         load_start;
    logic                         byte_valid;
    logic [7:0]                   byte_data;
    logic                         byte_ready;
    logic                         im_wr_en;
    logic [ADDRESS_WIDTH-1:0]     im_wr_addr;
    logic [INSTRUCTION_WIDTH-1:0] im_wr_data;
    logic                         startProcess;
    logic                         endProcess;
    logic                         loader_busy;
    logic                         load_error;

    // Host / processor side
    modport master (
        output load_start, byte_valid, byte_data, endProcess,
        input  byte_ready, im_wr_en, im_wr_addr, im_wr_data,
               startProcess, loader_busy, load_error
    );

    // Loader side
    modport slave (
        input  load_start, byte_valid, byte_data, endProcess,
        output byte_ready, im_wr_en, im_wr_addr, im_wr_data,
               startProcess, loader_busy, load_error
    );
endinterface

// File: rtl/ins_loader.sv
// Program loader: parses a 16-bit word-count header, assembles little-endian
// instructions into instruction memory, then starts the processor and waits for it.
module ins_loader #(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned IM_MEM_DEPTH      = 512,
    parameter int unsigned ADDRESS_WIDTH     = 32
) (
    input  logic         clk,
    input  logic         rst,
    ins_loader_if.slave  bus
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned ASM_W   = INSTRUCTION_WIDTH - BYTE_W;
    localparam logic [COUNT_W-1:0] MAX_WORDS = COUNT_W'(IM_MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        START = 3'd3,
        RUN   = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t                       state,      stateNext;
    logic [1:0]                   byteCnt,    byteCntNext;
    logic [COUNT_W-1:0]           wordIdx,    wordIdxNext;
    logic [COUNT_W-1:0]           wordCount,  wordCountNext;
    logic [ASM_W-1:0]             asmWord,    asmWordNext;
    logic                         byteReady,  byteReadyNext;
    logic                         wrEn,       wrEnNext;
    logic [ADDRESS_WIDTH-1:0]     wrAddr,     wrAddrNext;
    logic [INSTRUCTION_WIDTH-1:0] wrData,     wrDataNext;
    logic                         startPulse, startPulseNext;
    logic                         busy,       busyNext;
    logic                         errFlag,    errFlagNext;

    logic                         accept;
    logic [COUNT_W-1:0]           hdrCount;

    assign accept   = bus.byte_valid && byteReady;
    assign hdrCount = {bus.byte_data, wordCount[BYTE_W-1:0]};

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byteCnt    <= '0;
            wordIdx    <= '0;
            wordCount  <= '0;
            asmWord    <= '0;
            byteReady  <= 1'b0;
            wrEn       <= 1'b0;
            wrAddr     <= '0;
            wrData     <= '0;
            startPulse <= 1'b0;
            busy       <= 1'b0;
            errFlag    <= 1'b0;
        end else begin
            state      <= stateNext;
            byteCnt    <= byteCntNext;
            wordIdx    <= wordIdxNext;
            wordCount  <= wordCountNext;
            asmWord    <= asmWordNext;
            byteReady  <= byteReadyNext;
            wrEn       <= wrEnNext;
            wrAddr     <= wrAddrNext;
            wrData     <= wrDataNext;
            startPulse <= startPulseNext;
            busy       <= busyNext;
            errFlag    <= errFlagNext;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        stateNext      = state;
        byteCntNext    = byteCnt;
        wordIdxNext    = wordIdx;
        wordCountNext  = wordCount;
        asmWordNext    = asmWord;
        wrEnNext       = 1'b0;
        wrAddrNext     = wrAddr;
        wrDataNext     = wrData;
        startPulseNext = 1'b0;

        unique case (state)
            IDLE, ERR: begin
                if (bus.load_start) begin
                    stateNext   = HDR;
                    byteCntNext = '0;
                    wordIdxNext = '0;
                end
            end

            HDR: begin
                if (accept) begin
                    if (byteCnt == 2'd0) begin
                        wordCountNext[BYTE_W-1:0] = bus.byte_data;
                        byteCntNext               = 2'd1;
                    end else begin
                        wordCountNext = hdrCount;
                        byteCntNext   = '0;
                        wordIdxNext   = '0;
                        if (hdrCount == '0 || hdrCount > MAX_WORDS) begin
                            stateNext = ERR;
                        end else begin
                            stateNext = DATA;
                        end
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    if (byteCnt == 2'd3) begin
                        // Fourth byte completes the word; write it next cycle
                        wrEnNext    = 1'b1;
                        wrAddrNext  = ADDRESS_WIDTH'({wordIdx, 2'b00});
                        wrDataNext  = {bus.byte_data, asmWord};
                        byteCntNext = '0;
                        wordIdxNext = wordIdx + COUNT_W'(1);
                        if (wordIdx == wordCount - COUNT_W'(1)) begin
                            stateNext = START;
                        end
                    end else begin
                        // Shift in from the top so byte 0 ends at the LSB
                        asmWordNext = {bus.byte_data, asmWord[ASM_W-1:BYTE_W]};
                        byteCntNext = byteCnt + 2'd1;
                    end
                end
            end

            START: begin
                startPulseNext = 1'b1;
                stateNext      = RUN;
            end

            RUN: begin
                if (bus.endProcess) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Status outputs track the state being entered so they align with it
    always_comb begin
        byteReadyNext = (stateNext == HDR) || (stateNext == DATA);
        busyNext      = (stateNext == HDR) || (stateNext == DATA) ||
                        (stateNext == START) || (stateNext == RUN);
        errFlagNext   = (stateNext == ERR);
    end

    assign bus.byte_ready   = byteReady;
    assign bus.im_wr_en     = wrEn;
    assign bus.im_wr_addr   = wrAddr;
    assign bus.im_wr_data   = wrData;
    assign bus.startProcess = startPulse;
    assign bus.loader_busy  = busy;
    assign bus.load_error   = errFlag;

endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader: header table, directed corner sequences and random
// program loads checked against a stream-level reference model.
module tb_ins_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ins_loader_if #(.ADDRESS_WIDTH(32), .INSTRUCTION_WIDTH(32)) bus ();

    ins_loader #(
        .INSTRUCTION_WIDTH(32),
        .IM_MEM_DEPTH     (512),
        .ADDRESS_WIDTH    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         gap;
        bit         expErr;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    int          startCnt = 0;

    int          expN;
    logic [31:0] expAddrQ[$];
    logic [31:0] expDataQ[$];

    // Observed memory writes and start pulses
    always @(negedge clk) begin
        if (!rst && bus.im_wr_en) begin
            wrAddrQ.push_back(bus.im_wr_addr);
            wrDataQ.push_back(bus.im_wr_data);
        end
        if (!rst && bus.startProcess) startCnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: header gives N, then each group of 4 bytes is one LE word at 4*k
    task automatic computeExpected(input logic [7:0] s[$]);
        expAddrQ.delete();
        expDataQ.delete();
        expN = int'(s[0]) + 256 * int'(s[1]);
        if (expN >= 1 && expN <= 512) begin
            for (int k = 0; k < expN; k++) begin
                expAddrQ.push_back(32'(4 * k));
                expDataQ.push_back(32'(s[2+4*k]) + (32'(s[3+4*k]) << 8) +
                                   (32'(s[4+4*k]) << 16) + (32'(s[5+4*k]) << 24));
            end
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.byte_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL byte_accept: byte_ready got 0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic sendStream(input logic [7:0] s[$], input int gap, input int pokeIdx);
        for (int i = 0; i < s.size(); i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.byte_valid = 1'b0;
                    bus.byte_data  = 8'($urandom);
                    @(negedge clk);
                    check("gap_ready", 32'(bus.byte_ready), 32'd1);
                end
            end
            bus.load_start = (i == pokeIdx);
            bus.endProcess = (i == pokeIdx);
            sendByte(s[i]);
            bus.load_start = 1'b0;
            bus.endProcess = 1'b0;
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic startLoad(input string tag);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        check({tag, "_hdr_ready"}, 32'(bus.byte_ready), 32'd1);
        check({tag, "_hdr_busy"},  32'(bus.loader_busy), 32'd1);
        check({tag, "_hdr_noerr"}, 32'(bus.load_error), 32'd0);
    endtask

    task automatic finishRun(input string tag);
        bus.endProcess = 1'b1;
        @(negedge clk);
        bus.endProcess = 1'b0;
        check({tag, "_end_busy"},  32'(bus.loader_busy), 32'd0);
        check({tag, "_end_ready"}, 32'(bus.byte_ready), 32'd0);
    endtask

    task automatic runLoad(input logic [7:0] s[$], input int gap, input int pokeIdx,
                           input bit expErr, input string tag);
        int wrBase;
        int stBase;
        computeExpected(s);
        wrBase = wrAddrQ.size();
        stBase = startCnt;
        startLoad(tag);
        sendStream(s, gap, pokeIdx);
        if (expErr) begin
            check({tag, "_err"},       32'(bus.load_error), 32'd1);
            check({tag, "_err_ready"}, 32'(bus.byte_ready), 32'd0);
            check({tag, "_err_busy"},  32'(bus.loader_busy), 32'd0);
            repeat (3) @(negedge clk);
            check({tag, "_err_hold"},   32'(bus.load_error), 32'd1);
            check({tag, "_err_writes"}, 32'(wrAddrQ.size() - wrBase), 32'd0);
            check({tag, "_err_start"},  32'(startCnt - stBase), 32'd0);
        end else begin
            check({tag, "_last_wr"},    32'(bus.im_wr_en), 32'd1);
            check({tag, "_last_ready"}, 32'(bus.byte_ready), 32'd0);
            check({tag, "_pre_start"},  32'(bus.startProcess), 32'd0);
            @(negedge clk);
            check({tag, "_start"},      32'(bus.startProcess), 32'd1);
            check({tag, "_start_nowr"}, 32'(bus.im_wr_en), 32'd0);
            @(negedge clk);
            check({tag, "_start_once"}, 32'(bus.startProcess), 32'd0);
            check({tag, "_run_busy"},   32'(bus.loader_busy), 32'd1);
            if (pokeIdx >= 0) begin
                bus.load_start = 1'b1;
                @(negedge clk);
                bus.load_start = 1'b0;
                @(negedge clk);
                check({tag, "_poke_busy"},  32'(bus.loader_busy), 32'd1);
                check({tag, "_poke_ready"}, 32'(bus.byte_ready), 32'd0);
                check({tag, "_poke_start"}, 32'(bus.startProcess), 32'd0);
            end
            check({tag, "_nwrites"}, 32'(wrAddrQ.size() - wrBase), 32'(expN));
            for (int k = 0; k < expN && wrBase + k < wrAddrQ.size(); k++) begin
                check({tag, "_addr"}, wrAddrQ[wrBase+k], expAddrQ[k]);
                check({tag, "_data"}, wrDataQ[wrBase+k], expDataQ[k]);
            end
            check({tag, "_nstart"}, 32'(startCnt - stBase), 32'd1);
            finishRun(tag);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(bus.im_wr_en), 32'd0);
        check({tag, "_addr"},  bus.im_wr_addr, 32'd0);
        check({tag, "_data"},  bus.im_wr_data, 32'd0);
        check({tag, "_start"}, 32'(bus.startProcess), 32'd0);
        check({tag, "_busy"},  32'(bus.loader_busy), 32'd0);
        check({tag, "_err"},   32'(bus.load_error), 32'd0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [7:0]  s[$];
        int          n;
        int          base;

        vecs[0] = '{lo: 8'h00, hi: 8'h00, gap: 0, expErr: 1'b1};
        vecs[1] = '{lo: 8'h01, hi: 8'h02, gap: 0, expErr: 1'b1};
        vecs[2] = '{lo: 8'h00, hi: 8'h02, gap: 0, expErr: 1'b0};
        vecs[3] = '{lo: 8'hFF, hi: 8'hFF, gap: 2, expErr: 1'b1};
        vecs[4] = '{lo: 8'h01, hi: 8'h00, gap: 2, expErr: 1'b0};
        vecs[5] = '{lo: 8'h05, hi: 8'h00, gap: 1, expErr: 1'b0};

        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.endProcess = 1'b0;

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.byte_ready), 32'd0);

        // Test-plan program: two instructions, continuous then with 3-cycle gaps
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        for (int g = 0; g <= 3; g += 3) begin
            base = wrAddrQ.size();
            runLoad(s, g, -1, 1'b0, (g == 0) ? "normal" : "gap3");
            if (wrAddrQ.size() >= base + 2) begin
                check("prog_addr0", wrAddrQ[base],   32'h0000_0000);
                check("prog_data0", wrDataQ[base],   32'h0010_0513);
                check("prog_addr1", wrAddrQ[base+1], 32'h0000_0004);
                check("prog_data1", wrDataQ[base+1], 32'h0020_0593);
            end else begin
                check("prog_count", 32'(wrAddrQ.size() - base), 32'd2);
            end
        end

        // Header table: errors, recovery from ERR, maximum size
        foreach (vecs[i]) begin
            s.delete();
            s.push_back(vecs[i].lo);
            s.push_back(vecs[i].hi);
            n = int'(vecs[i].lo) + 256 * int'(vecs[i].hi);
            if (!vecs[i].expErr) begin
                for (int j = 0; j < 4 * n; j++) s.push_back(8'($urandom));
            end
            runLoad(s, vecs[i].gap, -1, vecs[i].expErr, $sformatf("vec%0d", i));
        end

        // Reset after two bytes of word 1
        startLoad("rstmid");
        s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sendStream(s, 0, -1);
        rst = 1'b1;
        #1;
        checkAllZero("rstmid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_idle_ready", 32'(bus.byte_ready), 32'd0);
        s = '{8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        runLoad(s, 0, -1, 1'b0, "after_rst");

        // load_start/endProcess during DATA and load_start during RUN are ignored
        s = '{8'h03, 8'h00};
        for (int j = 0; j < 12; j++) s.push_back(8'($urandom));
        runLoad(s, 1, 7, 1'b0, "poke");

        // Random loads
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 8));
            s.delete();
            s.push_back(8'(n));
            s.push_back(8'h00);
            for (int j = 0; j < 4 * n; j++) s.push_back(8'($urandom));
            runLoad(s, int'($urandom_range(0, 2)), -1, 1'b0, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
